// File: rtl/vortex_ctrl_pkg.sv
// Shared types and register map for the multi-core Vortex control block.
package vortex_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} core_state_t;

    // Per-core register offsets within a CORE_STRIDE block
    localparam logic [3:0]  CTRL_OFF       = 4'h0;
    localparam logic [3:0]  STATUS_OFF     = 4'h4;
    localparam logic [3:0]  PC_OFF         = 4'h8;
    localparam logic [3:0]  CYCLES_OFF     = 4'hC;
    localparam int          CORE_STRIDE    = 16;
    localparam logic [31:0] GLOBAL_BASE    = 32'h100;
    localparam logic [31:0] IRQ_EN_OFF     = GLOBAL_BASE;
    localparam logic [31:0] IRQ_STATUS_OFF = GLOBAL_BASE + 32'h4;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_START_ERR = 2;

endpackage

// File: rtl/bus_protocol_if.sv
// Simple peripheral bus: single-cycle write/read requests with combinational response.
interface bus_protocol_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      wen;
    logic                      ren;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      error;
    logic                      request_stall;

    modport master (output wen, ren, addr, wdata, strobe,
                    input  rdata, error, request_stall);
    modport slave  (input  wen, ren, addr, wdata, strobe,
                    output rdata, error, request_stall);
endinterface

// File: rtl/vortex_core_ctrl.sv
// Per-core run sequencer: reset hold, run-cycle counting and sticky DONE/START_ERR flags.
module vortex_core_ctrl
    import vortex_ctrl_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        clr_done,
    input  logic        clr_err,
    input  logic        core_busy,
    output logic        core_reset,
    output logic        busy,
    output logic        idle,
    output logic        done,
    output logic        start_err,
    output logic [31:0] cycles
);
    localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

    core_state_t   state_q, state_d;
    logic [HW-1:0] hold_q;
    logic          seen_busy_q;
    logic          go;

    // ABORT in the same write suppresses START entirely
    assign go = start && !abort;

    always_comb begin
        state_d    = state_q;
        core_reset = 1'b1;
        busy       = 1'b0;
        idle       = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (go) state_d = HOLD;
                HOLD:    if (hold_q == HW'(RESET_HOLD_CYCLES - 1)) state_d = RUN;
                RUN:     if (seen_busy_q && !core_busy) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        case (state_q)
            IDLE:    idle = 1'b1;
            RUN:     begin core_reset = 1'b0; busy = 1'b1; end
            DONE:    core_reset = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            seen_busy_q <= 1'b0;
            cycles      <= '0;
            done        <= 1'b0;
            start_err   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == IDLE && go) begin
                hold_q      <= '0;
                seen_busy_q <= 1'b0;
                cycles      <= '0;
            end else begin
                if (state_q == HOLD) hold_q <= hold_q + 1'b1;
                if (state_q == RUN && core_busy) seen_busy_q <= 1'b1;
                if (state_q == RUN && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
            end

            // hardware set beats a same-cycle software clear
            if (state_q == DONE && !abort)   done <= 1'b1;
            else if (state_q == IDLE && go)  done <= 1'b0;
            else if (clr_done)               done <= 1'b0;

            if (clr_err)                     start_err <= 1'b0;
            else if (go && state_q != IDLE)  start_err <= 1'b1;
        end
    end

endmodule

// File: rtl/vortex_multi_ctrl_regs.sv
// Register front-end for N Vortex cores: decode, PC reset values, IRQ enable and read mux.
module vortex_multi_ctrl_regs
    import vortex_ctrl_pkg::*;
#(
    parameter int          N_CORES                = 2,
    parameter int          DATA_WIDTH             = 32,
    parameter int          ADDR_WIDTH             = 32,
    parameter logic [31:0] PC_RESET_VAL_RESET_VAL = 32'hF000_0000,
    parameter int          RESET_HOLD_CYCLES      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    bus_protocol_if.slave             bus,
    input  logic [N_CORES-1:0]        core_busy,
    output logic [N_CORES-1:0]        core_reset,
    output logic [N_CORES-1:0][31:0]  core_pc_reset_val,
    output logic                      irq
);
    logic [3:0]                off;
    logic                      req, misalign, core_hit, irq_en_hit, irq_st_hit;
    logic                      mapped, ro_hit, pc_locked, err, wr_ok, rd_ok;
    logic [N_CORES-1:0]        sel, idle, run_st, done, start_err, irq_en_q;
    logic [N_CORES-1:0][31:0]  cycles;
    logic [DATA_WIDTH-1:0]     rd_mux;

    assign off        = bus.addr[3:0];
    assign req        = bus.wen || bus.ren;
    assign misalign   = |bus.addr[1:0];
    assign core_hit   = bus.addr[ADDR_WIDTH-1:4] < (ADDR_WIDTH-4)'(N_CORES);
    assign irq_en_hit = bus.addr == ADDR_WIDTH'(IRQ_EN_OFF);
    assign irq_st_hit = bus.addr == ADDR_WIDTH'(IRQ_STATUS_OFF);
    assign mapped     = core_hit || irq_en_hit || irq_st_hit;
    assign ro_hit     = (core_hit && off == CYCLES_OFF) || irq_st_hit;
    // PC of a core that is not idle is locked against writes
    assign pc_locked  = (|(sel & ~idle)) && off == PC_OFF;
    assign err        = (req && (misalign || !mapped)) || (bus.wen && (ro_hit || pc_locked));
    assign wr_ok      = bus.wen && !err;
    assign rd_ok      = bus.ren && !err;

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
        logic        wr_i;
        logic [31:0] pc_q;

        assign sel[i] = core_hit && bus.addr[7:4] == 4'(i);
        assign wr_i   = wr_ok && sel[i];

        vortex_core_ctrl #(.RESET_HOLD_CYCLES(RESET_HOLD_CYCLES)) u_ctrl (
            .clk        (clk),
            .reset      (reset),
            .start      (wr_i && off == CTRL_OFF && bus.wdata[CTRL_START]),
            .abort      (wr_i && off == CTRL_OFF && bus.wdata[CTRL_ABORT]),
            .clr_done   (wr_i && off == STATUS_OFF && bus.wdata[STAT_DONE]),
            .clr_err    (wr_i && off == STATUS_OFF && bus.wdata[STAT_START_ERR]),
            .core_busy  (core_busy[i]),
            .core_reset (core_reset[i]),
            .busy       (run_st[i]),
            .idle       (idle[i]),
            .done       (done[i]),
            .start_err  (start_err[i]),
            .cycles     (cycles[i])
        );

        always_ff @(posedge clk) begin
            if (reset) begin
                pc_q <= PC_RESET_VAL_RESET_VAL;
            end else if (wr_i && off == PC_OFF) begin
                for (int b = 0; b < 4; b++)
                    if (bus.strobe[b]) pc_q[8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end

        assign core_pc_reset_val[i] = pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_ok && irq_en_hit) irq_en_q <= bus.wdata[N_CORES-1:0];
            irq <= |(done & irq_en_q);
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (sel[i]) begin
                case (off)
                    STATUS_OFF: begin
                        rd_mux[STAT_BUSY]      = run_st[i];
                        rd_mux[STAT_DONE]      = done[i];
                        rd_mux[STAT_START_ERR] = start_err[i];
                    end
                    PC_OFF:     rd_mux = core_pc_reset_val[i];
                    CYCLES_OFF: rd_mux = cycles[i];
                    default:    ;
                endcase
            end
        end
        if (irq_en_hit) rd_mux = DATA_WIDTH'(irq_en_q);
        if (irq_st_hit) rd_mux = DATA_WIDTH'(done);
    end

    assign bus.rdata         = rd_ok ? rd_mux : '0;
    assign bus.error         = err;
    assign bus.request_stall = 1'b0;

endmodule

// File: tb/tb_vortex_multi_ctrl_regs.sv
// Directed scoreboard bench for vortex_multi_ctrl_regs (2 cores, 4-cycle reset hold).
module tb_vortex_multi_ctrl_regs;
    localparam int N = 2;
    localparam int H = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        core_busy = '0;
    logic [N-1:0]        core_reset;
    logic [N-1:0][31:0]  pcv;
    logic                irq;
    int                  tests = 0;
    int                  fails = 0;
    int                  n;
    logic [31:0]         sb[$];

    bus_protocol_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    vortex_multi_ctrl_regs #(.N_CORES(N), .RESET_HOLD_CYCLES(H)) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .core_busy         (core_busy),
        .core_reset        (core_reset),
        .core_pc_reset_val (pcv),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
            return;
        end
        exp = sb.pop_front();
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb.push_back(exp);
        chk(tag, obs);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic e, input string tag);
        bus.wen = 1'b1; bus.addr = a; bus.wdata = d; bus.strobe = s;
        sb.push_back(32'(e));
        #1 chk(tag, 32'(bus.error));
        @(negedge clk);
        bus.wen = 1'b0; bus.strobe = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic e, input string tag);
        bus.ren = 1'b1; bus.addr = a;
        sb.push_back(exp);
        sb.push_back(32'(e));
        #1 chk(tag, bus.rdata);
        chk({tag, "_err"}, 32'(bus.error));
        @(negedge clk);
        bus.ren = 1'b0;
    endtask

    task automatic wait_run(input int c, output int cnt);
        cnt = 0;
        while (core_reset[c] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = '0; bus.wdata = '0; bus.strobe = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        expect_val("rst_core_reset", 32'(core_reset), 32'h3);
        expect_val("rst_irq", 32'(irq), 0);
        expect_val("rst_error", 32'(bus.error), 0);
        expect_val("rst_rdata", bus.rdata, 0);
        rd(32'h18, 32'hF000_0000, 1'b0, "pc1_rst");
        rd(32'h100, 0, 1'b0, "irq_en_rst");
        rd(32'h0C, 0, 1'b0, "cyc0_rst");

        wr(32'h08, 32'h8000_0000, 4'hF, 1'b0, "pc0_wr");
        rd(32'h08, 32'h8000_0000, 1'b0, "pc0_rd");
        expect_val("pc0_port", pcv[0], 32'h8000_0000);
        wr(32'h18, 32'h1234_5678, 4'b0101, 1'b0, "pc1_strb_wr");
        rd(32'h18, 32'hF034_0078, 1'b0, "pc1_strb_rd");
        expect_val("pc1_port", pcv[1], 32'hF034_0078);

        // full run of core0: busy 3 cycles after release, for 10 cycles
        wr(32'h00, 32'h1, 4'hF, 1'b0, "start0");
        wait_run(0, n);
        expect_val("hold_cycles0", 32'(n), 32'(H));
        repeat (3) @(negedge clk);
        core_busy[0] = 1'b1;
        repeat (10) @(negedge clk);
        core_busy[0] = 1'b0;
        @(negedge clk);
        expect_val("done_state_reset", 32'(core_reset[0]), 0);
        @(negedge clk);
        expect_val("back_idle_reset", 32'(core_reset[0]), 1);
        rd(32'h04, 32'h2, 1'b0, "status0_done");
        rd(32'h0C, 32'd14, 1'b0, "cycles0");
        expect_val("irq_masked0", 32'(irq), 0);
        wr(32'h0C, 32'h5, 4'hF, 1'b1, "cycles_ro_wr");
        rd(32'h0C, 32'd14, 1'b0, "cycles_ro_keep");

        // interrupt path
        wr(32'h04, 32'h2, 4'hF, 1'b0, "w1c_done0");
        rd(32'h04, 0, 1'b0, "status0_clr");
        wr(32'h100, 32'h1, 4'hF, 1'b0, "irq_en_wr");
        rd(32'h100, 32'h1, 1'b0, "irq_en_rd");
        wr(32'h00, 32'h1, 4'hF, 1'b0, "start0b");
        wait_run(0, n);
        expect_val("hold_cycles0b", 32'(n), 32'(H));
        core_busy[0] = 1'b1;
        @(negedge clk);
        core_busy[0] = 1'b0;
        bus.ren = 1'b1; bus.addr = 32'h104;
        n = 0;
        #1;
        while (bus.rdata[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            #1 n++;
        end
        expect_val("irq_status_done", bus.rdata, 32'h1);
        expect_val("irq_lag", 32'(irq), 0);
        @(negedge clk);
        #1 expect_val("irq_set", 32'(irq), 1);
        bus.ren = 1'b0;
        wr(32'h04, 32'h2, 4'hF, 1'b0, "w1c_irq");
        expect_val("irq_hold", 32'(irq), 1);
        @(negedge clk);
        expect_val("irq_clr", 32'(irq), 0);

        // core1: start and PC write while running
        wr(32'h10, 32'h1, 4'hF, 1'b0, "start1");
        wait_run(1, n);
        expect_val("hold_cycles1", 32'(n), 32'(H));
        core_busy[1] = 1'b1;
        wr(32'h10, 32'h1, 4'hF, 1'b0, "start1_busy");
        rd(32'h14, 32'h5, 1'b0, "status1_err");
        wr(32'h18, 32'hDEAD_BEEF, 4'hF, 1'b1, "pc1_locked");
        rd(32'h18, 32'hF034_0078, 1'b0, "pc1_keep");
        expect_val("run1_continues", 32'(core_reset[1]), 0);
        wr(32'h14, 32'h4, 4'hF, 1'b0, "w1c_err1");
        rd(32'h14, 32'h1, 1'b0, "status1_clr");
        core_busy[1] = 1'b0;
        n = 0;
        while (!core_reset[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        rd(32'h14, 32'h2, 1'b0, "status1_done");
        expect_val("irq_masked1", 32'(irq), 0);

        // abort core0 mid-run: 6 RUN cycles including the abort cycle
        wr(32'h00, 32'h1, 4'hF, 1'b0, "start0c");
        wait_run(0, n);
        core_busy[0] = 1'b1;
        repeat (5) @(negedge clk);
        wr(32'h00, 32'h2, 4'hF, 1'b0, "abort0");
        expect_val("abort_reset", 32'(core_reset[0]), 1);
        core_busy[0] = 1'b0;
        rd(32'h0C, 32'd6, 1'b0, "cyc_frozen");
        repeat (3) @(negedge clk);
        rd(32'h0C, 32'd6, 1'b0, "cyc_frozen2");
        rd(32'h04, 0, 1'b0, "abort_no_done");
        expect_val("abort_irq", 32'(irq), 0);

        wr(32'h00, 32'h3, 4'hF, 1'b0, "start_abort");
        repeat (6) @(negedge clk);
        expect_val("start_abort_idle", 32'(core_reset[0]), 1);
        rd(32'h04, 0, 1'b0, "start_abort_status");

        // error responses
        rd(32'h0FC, 0, 1'b1, "unmapped_rd");
        wr(32'h104, 32'h0, 4'hF, 1'b1, "irq_status_wr");
        rd(32'h104, 32'h2, 1'b0, "irq_status_rd");
        rd(32'h100, 32'h1, 1'b0, "irq_en_keep");
        rd(32'h02, 0, 1'b1, "misalign_rd");
        wr(32'h0A, 32'h1111_1111, 4'hF, 1'b1, "misalign_wr");
        rd(32'h08, 32'h8000_0000, 1'b0, "pc0_keep");
        wr(32'h20, 32'h1, 4'hF, 1'b1, "no_core2");

        // reset while core1 runs
        wr(32'h10, 32'h1, 4'hF, 1'b0, "start1d");
        wait_run(1, n);
        expect_val("hold_cycles1d", 32'(n), 32'(H));
        core_busy[1] = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        core_busy[1] = 1'b0;
        expect_val("mid_rst_core_reset", 32'(core_reset), 32'h3);
        expect_val("mid_rst_irq", 32'(irq), 0);
        rd(32'h08, 32'hF000_0000, 1'b0, "mid_rst_pc0");
        rd(32'h100, 0, 1'b0, "mid_rst_irq_en");
        rd(32'h14, 0, 1'b0, "mid_rst_status1");
        rd(32'h1C, 0, 1'b0, "mid_rst_cycles1");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vortex_multi_ctrl_regs.md
Name: vortex_multi_ctrl_regs

Overview:
Control/status register block for N Vortex core instances behind one bus_protocol_if peripheral_vital port. Each core has its own start/abort control, busy/done status, PC reset value and run-cycle counter. A done interrupt is raised per core and gated by a global enable. Sits between the AHB subordinate adapter and the Vortex instances, driving each core's reset and PC_reset_val.

Parameters:
N_CORES, 2, number of Vortex cores controlled (1..16)
DATA_WIDTH, 32, bus data width (fixed 32)
ADDR_WIDTH, 32, bus offset address width
PC_RESET_VAL_RESET_VAL, 32'hF000_0000, reset value of every PC_RESET_VAL register
RESET_HOLD_CYCLES, 4, cycles core reset stays high after start (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wen  in  1  bus write request
ren  in  1  bus read request
addr  in  ADDR_WIDTH  offset address
wdata  in  32  write data
strobe  in  4  byte enables
rdata  out  32  read data
error  out  1  bus error
request_stall  out  1  wait-state request
core_busy  in  N_CORES  Vortex busy per core
core_reset  out  N_CORES  Vortex reset per core
core_pc_reset_val  out  N_CORES*32  PC reset value per core, core i at [32i+31:32i]
irq  out  1  OR of enabled done interrupts

Behaviour:
- Address map: core i block at 16*i. +0x0 CTRL (W): bit0 START, bit1 ABORT, self-clearing, read 0. +0x4 STATUS (R, W1C): bit0 BUSY (RO, from FSM RUN), bit1 DONE (sticky), bit2 START_ERR (sticky). +0x8 PC_RESET_VAL (RW, byte strobes honoured). +0xC CYCLES (RO). Global at 0x100: IRQ_EN (RW, bits[N_CORES-1:0]); 0x104 IRQ_STATUS (RO, = DONE bits).
- Unmapped address, write to RO register, or addr[1:0]!=0 -> error=1 the same cycle as the request, no state change, rdata=0.
- rdata combinational from addr when ren; 0 otherwise. request_stall tied 0.
- Per-core FSM, states IDLE, HOLD, RUN, DONE:
  IDLE: core_reset=1. START -> HOLD; cycle counter cleared; DONE cleared.
  HOLD: core_reset=1; hold counter counts RESET_HOLD_CYCLES, then -> RUN.
  RUN: core_reset=0; CYCLES increments by 1 every cycle, saturating at 0xFFFF_FFFF. Core busy must be seen high at least once (seen_busy flag). Then core_busy low -> DONE.
  DONE: single cycle; sets DONE sticky; -> IDLE (core_reset=1 the next cycle).
  ABORT in any state -> IDLE next cycle; DONE is not set; CYCLES is frozen.
- START while not IDLE: ignored and START_ERR set. START and ABORT both set in one write: ABORT wins.
- PC_RESET_VAL write while not IDLE: ignored, error=1. core_pc_reset_val is the register value at all times.
- DONE W1C in the same cycle as a hardware set: the set wins. START_ERR W1C has normal priority.
- irq = |(DONE & IRQ_EN), registered, so it lags DONE by 1 cycle.
- reset: all FSMs IDLE, core_reset all 1, PC regs = PC_RESET_VAL_RESET_VAL, CYCLES/DONE/START_ERR/IRQ_EN = 0, irq = 0, error = 0, rdata = 0. reset mid-RUN has the same effect.
- Start-to-core_reset-low latency: the START write lands at cycle t; core_reset falls at t+1+RESET_HOLD_CYCLES.

Decomposition:
- Package vortex_ctrl_pkg holds:
  - typedef enum core_state_t {IDLE, HOLD, RUN, DONE}
  - register offset localparams (CTRL, STATUS, PC, CYCLES, IRQ_EN, IRQ_STATUS, CORE_STRIDE=16, GLOBAL_BASE=0x100)
  - STATUS bit index constants
- Sub-module vortex_core_ctrl is generated N_CORES times. It contains the FSM, hold counter, cycle counter, seen_busy, and the DONE/START_ERR flags.
- The top level contains address decode, PC registers, IRQ_EN, and the read mux.

Test Plan:
- Reset, then read core1 PC (0x18) -> 0xF000_0000. core_reset=2'b11. irq=0.
- Write PC0=0x8000_0000, then START core0. Drive busy high 3 cycles after core_reset falls and low 10 cycles later -> core_reset low after 4 hold cycles. DONE0=1. CYCLES0 = RUN-cycle count. core_reset0 returns to 1.
- IRQ_EN=1, core0 completes -> irq=1 one cycle after DONE. W1C STATUS0 bit1 -> irq=0 the next cycle.
- START core1 while it is in RUN -> START_ERR1=1 and the FSM continues. Write PC1 in RUN -> error=1, value unchanged.
- ABORT core0 in RUN -> core_reset0=1 next cycle. DONE0 stays 0. CYCLES0 is frozen.
- Read 0x0FC, write 0x104, or read misaligned 0x02 -> error=1, rdata=0, no state change.
